// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential 8x8 unsigned shift-and-add multiplier that borrows the
// shared datapath ALU (add and rotate-through-carry) for every arithmetic step.
module alu_mul_seq #(
    parameter bit SKIP_ZERO_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] p,
    output logic        pz,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_st_in,
    input  logic [7:0]  alu_r,
    input  logic [7:0]  alu_st_out
);

    // Shared ALU encoding: op codes and the carry flag position in st_in/st_out.
    localparam logic [3:0] ALU_TRA = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_ROR = 4'h9;
    localparam int         ALU_CF  = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_RORH = 3'd2,
        S_RORL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_m;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_c;
    logic [2:0]  r_cnt;
    logic [15:0] r_p;
    logic        r_pz;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [7:0]  w_m_nxt;
    logic [7:0]  w_hi_nxt;
    logic [7:0]  w_lo_nxt;
    logic        w_c_nxt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] w_p_nxt;
    logic        w_pz_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic [7:0]  w_alu_a;
    logic [7:0]  w_alu_b;
    logic [3:0]  w_alu_op;
    logic [7:0]  w_alu_st_in;
    logic        w_unused_st;

    // Only the carry flag of the ALU status is meaningful here.
    assign w_unused_st = ^alu_st_out;

    // Next-state, datapath register updates and ALU drive for the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_c_nxt     = r_c;
        w_cnt_nxt   = r_cnt;
        w_p_nxt     = r_p;
        w_pz_nxt    = r_pz;
        w_alu_a     = 8'h00;
        w_alu_b     = 8'h00;
        w_alu_op    = ALU_TRA;
        w_alu_st_in = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_m_nxt   = a_in;
                    w_hi_nxt  = 8'h00;
                    w_lo_nxt  = b_in;
                    w_c_nxt   = 1'b0;
                    w_cnt_nxt = 3'd0;
                    if (SKIP_ZERO_ADD && !b_in[0]) begin
                        w_state_nxt = S_RORH;
                    end else begin
                        w_state_nxt = S_ADD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADD: begin
                // st_in stays zero so a carry left over from a rotate is never added.
                w_alu_op    = ALU_ADD;
                w_alu_a     = r_hi;
                w_alu_b     = r_lo[0] ? r_m : 8'h00;
                w_hi_nxt    = alu_r;
                w_c_nxt     = alu_st_out[ALU_CF];
                w_state_nxt = S_RORH;
            end
            S_RORH: begin
                w_alu_op            = ALU_ROR;
                w_alu_a             = r_hi;
                w_alu_st_in[ALU_CF] = r_c;
                w_hi_nxt            = alu_r;
                w_c_nxt             = alu_st_out[ALU_CF];
                w_state_nxt         = S_RORL;
            end
            S_RORL: begin
                w_alu_op            = ALU_ROR;
                w_alu_a             = r_lo;
                w_alu_st_in[ALU_CF] = r_c;
                w_lo_nxt            = alu_r;
                if (r_cnt == 3'd7) begin
                    // Final lo comes straight from the ALU so p is valid while done is high.
                    w_p_nxt     = {r_hi, alu_r};
                    w_pz_nxt    = ~|{r_hi, alu_r};
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (SKIP_ZERO_ADD && !alu_r[0]) begin
                        w_c_nxt     = 1'b0;
                        w_state_nxt = S_RORH;
                    end else begin
                        w_state_nxt = S_ADD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_ADD, S_RORH, S_RORL: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_m     <= 8'h00;
            r_hi    <= 8'h00;
            r_lo    <= 8'h00;
            r_c     <= 1'b0;
            r_cnt   <= 3'd0;
            r_p     <= 16'h0000;
            r_pz    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_c     <= w_c_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p     <= w_p_nxt;
            r_pz    <= w_pz_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign p         = r_p;
    assign pz        = r_pz;
    assign alu_a     = w_alu_a;
    assign alu_b     = w_alu_b;
    assign alu_op    = w_alu_op;
    assign alu_st_in = w_alu_st_in;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: one fixed-latency and one zero-skipping instance, each
// wired to a behavioural ALU, checked against plain a*b and latency formulas.
module tb_alu_mul_seq;

    localparam logic [3:0] OP_TRA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_ROR = 4'h9;
    localparam int         CF     = 0;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;

    logic        busy0, done0, pz0, busy1, done1, pz1;
    logic [15:0] p0, p1;
    logic [7:0]  alu_a0, alu_b0, alu_st_in0, alu_r0, alu_st_out0;
    logic [7:0]  alu_a1, alu_b1, alu_st_in1, alu_r1, alu_st_out1;
    logic [3:0]  alu_op0, alu_op1;

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int overlap_cnt = 0;

    // Behavioural ALU: ADD uses carry-in, ROR rotates right through carry.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] st);
        logic [8:0] sum;
        logic [7:0] r;
        logic       c;
        sum = 9'd0;
        r   = 8'h00;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {8'h00, st[CF]};
                r   = sum[7:0];
                c   = sum[8];
            end
            OP_ROR: begin
                r = {st[CF], a[7:1]};
                c = a[0];
            end
            OP_TRA: begin
                r = a;
                c = 1'b0;
            end
            default: begin
                r = 8'hA5;
                c = 1'b1;
            end
        endcase
        return {r[6:1], (r == 8'h00), c, r};
    endfunction

    assign {alu_st_out0, alu_r0} = alu_fn(alu_op0, alu_a0, alu_b0, alu_st_in0);
    assign {alu_st_out1, alu_r1} = alu_fn(alu_op1, alu_a1, alu_b1, alu_st_in1);

    alu_mul_seq #(.SKIP_ZERO_ADD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy0), .done(done0), .p(p0), .pz(pz0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_st_in(alu_st_in0),
        .alu_r(alu_r0), .alu_st_out(alu_st_out0)
    );

    alu_mul_seq #(.SKIP_ZERO_ADD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy1), .done(done1), .p(p1), .pz(pz1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_st_in(alu_st_in1),
        .alu_r(alu_r1), .alu_st_out(alu_st_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses and any cycle where busy and done are high together.
    always @(negedge clk) begin
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if ((busy0 && done0) || (busy1 && done1)) overlap_cnt <= overlap_cnt + 1;
    end

    // Issue one request and measure start-edge-to-done latency of both instances.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int l0, output int l1);
        l0 = -1;
        l1 = -1;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int n = 1; n <= 40 && (l0 < 0 || l1 < 0); n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done0 && l0 < 0) l0 = n;
            if (done1 && l1 < 0) l1 = n;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({busy0, done0, busy1, done1} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy0, done0, busy1, done1}); end
        total++; if (p0 !== 16'h0000 || p1 !== 16'h0000) begin bad++; $display("FAIL reset_p got=%h/%h exp=0000", p0, p1); end
        total++; if (pz0 !== 1'b1 || pz1 !== 1'b1) begin bad++; $display("FAIL reset_pz got=%b/%b exp=1", pz0, pz1); end
        total++; if ({alu_op0, alu_a0, alu_b0, alu_st_in0} !== {OP_TRA, 24'h000000}) begin bad++; $display("FAIL reset_alu got=%h %h %h %h exp=TRA,0,0,0", alu_op0, alu_a0, alu_b0, alu_st_in0); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        int l0, l1;
        do_op(8'h0F, 8'h0F, l0, l1);
        total++; if (l0 !== 25) begin bad++; $display("FAIL lat_0f got=%0d exp=25", l0); end
        total++; if (l1 !== 21) begin bad++; $display("FAIL lat_0f_skip got=%0d exp=21", l1); end
        total++; if (p0 !== 16'h00E1 || pz0 !== 1'b0) begin bad++; $display("FAIL p_0f got=%h pz=%b exp=00e1 pz=0", p0, pz0); end
        total++; if (p1 !== 16'h00E1) begin bad++; $display("FAIL p_0f_skip got=%h exp=00e1", p1); end
    endtask

    task automatic test_op_sequence();
        logic [3:0] exp_op;
        a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_op = (i % 3 == 0) ? OP_ADD : OP_ROR;
            total++; if (alu_op0 !== exp_op) begin bad++; $display("FAIL op_seq[%0d] got=%h exp=%h", i, alu_op0, exp_op); end
            if (exp_op == OP_ADD) begin
                total++; if (alu_st_in0 !== 8'h00) begin bad++; $display("FAIL add_st_in[%0d] got=%h exp=00", i, alu_st_in0); end
            end
        end
        @(posedge clk); #1;
        total++; if (done0 !== 1'b1 || p0 !== 16'hFE01) begin bad++; $display("FAIL ff_x_ff done=%b got=%h exp=fe01", done0, p0); end
        total++; if (done1 !== 1'b1 || p1 !== 16'hFE01) begin bad++; $display("FAIL ff_x_ff_skip done=%b got=%h exp=fe01", done1, p1); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_multiplier();
        int l0, l1;
        do_op(8'h5A, 8'h00, l0, l1);
        total++; if (p0 !== 16'h0000 || pz0 !== 1'b1) begin bad++; $display("FAIL zero_p got=%h pz=%b exp=0000 pz=1", p0, pz0); end
        total++; if (l0 !== 25) begin bad++; $display("FAIL zero_lat got=%0d exp=25", l0); end
        total++; if (l1 !== 17 || pz1 !== 1'b1) begin bad++; $display("FAIL zero_lat_skip got=%0d pz=%b exp=17 pz=1", l1, pz1); end
        do_op(8'h5A, 8'h01, l0, l1);
        total++; if (l1 !== 18 || p1 !== 16'h005A) begin bad++; $display("FAIL one_skip lat=%0d p=%h exp=18 005a", l1, p1); end
        total++; if (p0 !== 16'h005A || pz0 !== 1'b0) begin bad++; $display("FAIL one_p got=%h pz=%b exp=005a pz=0", p0, pz0); end
    endtask

    task automatic test_ignore_start();
        int d0, d1;
        d0 = done_cnt0; d1 = done_cnt1;
        a_in = 8'h33; b_in = 8'h44; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = (n == 5);
            if (n == 5) begin a_in = 8'h02; b_in = 8'h03; end
        end
        total++; if (done_cnt0 - d0 !== 1 || done_cnt1 - d1 !== 1) begin bad++; $display("FAIL ignore_done_cnt got=%0d/%0d exp=1", done_cnt0 - d0, done_cnt1 - d1); end
        total++; if (p0 !== 16'h0D8C || p1 !== 16'h0D8C) begin bad++; $display("FAIL ignore_p got=%h/%h exp=0d8c", p0, p1); end
    endtask

    task automatic test_reset_mid();
        int d0, d1, l0, l1;
        a_in = 8'hAB; b_in = 8'hCD; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; start = 1'b0; end
        total++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b/%b exp=1", busy0, busy1); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if ({busy0, done0, busy1, done1} !== 4'b0000 || p0 !== 16'h0000 || pz0 !== 1'b1) begin bad++; $display("FAIL mid_reset flags=%b p=%h pz=%b exp=0000 0000 1", {busy0, done0, busy1, done1}, p0, pz0); end
        d0 = done_cnt0; d1 = done_cnt1;
        repeat (30) @(posedge clk);
        #1;
        total++; if (done_cnt0 !== d0 || done_cnt1 !== d1) begin bad++; $display("FAIL mid_no_done got=%0d/%0d exp=0", done_cnt0 - d0, done_cnt1 - d1); end
        do_op(8'h10, 8'h10, l0, l1);
        total++; if (p0 !== 16'h0100 || p1 !== 16'h0100 || l0 !== 25) begin bad++; $display("FAIL after_reset p=%h/%h lat=%0d exp=0100 25", p0, p1, l0); end
    endtask

    task automatic test_reset_with_start();
        reset = 1'b1; start = 1'b1; a_in = 8'h07; b_in = 8'h09;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        total++; if (busy0 !== 1'b0 || busy1 !== 1'b0 || p0 !== 16'h0000) begin bad++; $display("FAIL reset_start busy=%b/%b p=%h exp=0 0 0000", busy0, busy1, p0); end
    endtask

    task automatic test_random();
        logic [7:0]  ra, rb;
        logic [15:0] exp_p;
        int l0, l1;
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom());
            rb = 8'($urandom());
            exp_p = 16'(ra) * 16'(rb);
            do_op(ra, rb, l0, l1);
            total++; if (p0 !== exp_p || pz0 !== (exp_p == 16'h0000)) begin bad++; $display("FAIL rnd_p a=%h b=%h got=%h pz=%b exp=%h", ra, rb, p0, pz0, exp_p); end
            total++; if (p1 !== exp_p || pz1 !== (exp_p == 16'h0000)) begin bad++; $display("FAIL rnd_p_skip a=%h b=%h got=%h exp=%h", ra, rb, p1, exp_p); end
            total++; if (l0 !== 25 || l1 !== 17 + $countones(rb)) begin bad++; $display("FAIL rnd_lat b=%h got=%0d/%0d exp=25/%0d", rb, l0, l1, 17 + $countones(rb)); end
        end
    endtask

    task automatic test_overlap();
        total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL busy_done_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_known();
        test_op_sequence();
        test_zero_multiplier();
        test_ignore_start();
        test_reset_mid();
        test_reset_with_start();
        test_random();
        test_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
